// File: rtl/vram_arbiter_if.sv
// Bus bundle for vram_arbiter: video fetch port, CPU port and the RAM port.
// Optional DMA write port exists only when VRAM_ARB_DMA_EN is defined.
// slave  = the arbiter itself
// master = the environment (requesters plus the synchronous RAM)
interface vram_arbiter_if #(
  parameter int ADDR_W = 16
);
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_ack;
  logic [7:0]        vid_data;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_din;
  logic              cpu_ack;
  logic [7:0]        cpu_dout;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [7:0]        ram_din;
  logic [7:0]        ram_dout;

`ifdef VRAM_ARB_DMA_EN
  logic              dma_req;
  logic [ADDR_W-1:0] dma_addr;
  logic [7:0]        dma_din;
  logic              dma_ack;
`endif

  modport slave (
    input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_din, ram_dout,
    output vid_ack, vid_data, cpu_ack, cpu_dout, ram_addr, ram_we, ram_din
`ifdef VRAM_ARB_DMA_EN
    , input dma_req, dma_addr, dma_din
    , output dma_ack
`endif
  );

  modport master (
    output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_din, ram_dout,
    input  vid_ack, vid_data, cpu_ack, cpu_dout, ram_addr, ram_we, ram_din
`ifdef VRAM_ARB_DMA_EN
    , output dma_req, dma_addr, dma_din
    , input dma_ack
`endif
  );
endinterface

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one synchronous single-port RAM between a video fetch
// port and a CPU port. Video wins by default; after MAX_STREAK consecutive
// video grants made while the CPU waits, the CPU is granted once.
// Define VRAM_ARB_DMA_EN to add a write-only DMA port with top priority.
//
// state   | meaning
// IDLE    | arbitrate; latch winner's address/data into the RAM registers
// ISSUE   | RAM samples ram_addr (and ram_din/ram_we for writes)
// CAPTURE | ram_dout valid; registered into vid_data/cpu_dout at the edge
// ACK     | one-cycle ack pulse to the granted requester
module vram_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int MAX_STREAK = 4
) (
  input logic           clk_sys,
  input logic           reset,
  vram_arbiter_if.slave bus
);

  localparam int SW = (MAX_STREAK < 1) ? 1 : $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, ACK} state_t;
  typedef enum logic [1:0] {SRC_VID, SRC_CPU, SRC_DMA} src_t;

  state_t            state_q;
  src_t              src_q;
  logic              wr_q;
  logic [SW-1:0]     streak_q, streak_d;
  logic [ADDR_W-1:0] ram_addr_q;
  logic              ram_we_q;
  logic [7:0]        ram_din_q;
  logic              vid_ack_q, cpu_ack_q;
  logic [7:0]        vid_data_q, cpu_dout_q;
  logic              gnt_vid_d, gnt_cpu_d;
`ifdef VRAM_ARB_DMA_EN
  logic              gnt_dma_d;
  logic              dma_ack_q;
`endif

  // Priority pick among pending requests; only acted on while IDLE.
  always_comb begin
    gnt_vid_d = 1'b0;
    gnt_cpu_d = 1'b0;
`ifdef VRAM_ARB_DMA_EN
    gnt_dma_d = 1'b0;
    if (bus.dma_req) gnt_dma_d = 1'b1;
    else
`endif
    if (bus.vid_req && !(bus.cpu_req && streak_q == STREAK_MAX)) gnt_vid_d = 1'b1;
    else if (bus.cpu_req) gnt_cpu_d = 1'b1;
  end

  // Streak of video grants won while the CPU was waiting; DMA grants leave it alone.
  always_comb begin
    streak_d = streak_q;
    if (state_q == IDLE) begin
      if (!bus.cpu_req || gnt_cpu_d) streak_d = '0;
      else if (gnt_vid_d && streak_q != STREAK_MAX) streak_d = streak_q + SW'(1);
    end
  end

  // Access sequencer with registered RAM controls, read data and acks.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      src_q      <= SRC_VID;
      wr_q       <= 1'b0;
      streak_q   <= '0;
      ram_addr_q <= '0;
      ram_we_q   <= 1'b0;
      ram_din_q  <= '0;
      vid_ack_q  <= 1'b0;
      cpu_ack_q  <= 1'b0;
      vid_data_q <= '0;
      cpu_dout_q <= '0;
`ifdef VRAM_ARB_DMA_EN
      dma_ack_q  <= 1'b0;
`endif
    end else begin
      streak_q <= streak_d;
      case (state_q)
        IDLE: begin
`ifdef VRAM_ARB_DMA_EN
          if (gnt_dma_d) begin
            src_q      <= SRC_DMA;
            wr_q       <= 1'b1;
            ram_addr_q <= bus.dma_addr;
            ram_din_q  <= bus.dma_din;
            ram_we_q   <= 1'b1;
            state_q    <= ISSUE;
          end else
`endif
          if (gnt_vid_d) begin
            src_q      <= SRC_VID;
            wr_q       <= 1'b0;
            ram_addr_q <= bus.vid_addr;
            ram_we_q   <= 1'b0;
            state_q    <= ISSUE;
          end else if (gnt_cpu_d) begin
            src_q      <= SRC_CPU;
            wr_q       <= bus.cpu_we;
            ram_addr_q <= bus.cpu_addr;
            ram_din_q  <= bus.cpu_din;
            ram_we_q   <= bus.cpu_we;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          ram_we_q <= 1'b0;
          state_q  <= CAPTURE;
        end
        CAPTURE: begin
          if (src_q == SRC_VID) begin
            vid_data_q <= bus.ram_dout;
            vid_ack_q  <= 1'b1;
          end else if (src_q == SRC_CPU) begin
            if (!wr_q) cpu_dout_q <= bus.ram_dout;
            cpu_ack_q <= 1'b1;
          end
`ifdef VRAM_ARB_DMA_EN
          else dma_ack_q <= 1'b1;
`endif
          state_q <= ACK;
        end
        ACK: begin
          vid_ack_q <= 1'b0;
          cpu_ack_q <= 1'b0;
`ifdef VRAM_ARB_DMA_EN
          dma_ack_q <= 1'b0;
`endif
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ram_addr = ram_addr_q;
  assign bus.ram_we   = ram_we_q;
  assign bus.ram_din  = ram_din_q;
  assign bus.vid_ack  = vid_ack_q;
  assign bus.vid_data = vid_data_q;
  assign bus.cpu_ack  = cpu_ack_q;
  assign bus.cpu_dout = cpu_dout_q;
`ifdef VRAM_ARB_DMA_EN
  assign bus.dma_ack  = dma_ack_q;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a read-first synchronous RAM model.
// Inputs are driven and outputs sampled on the falling edge of clk_sys.
module tb_vram_arbiter;
  localparam int ADDR_W = 16;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  int   total   = 0;
  int   bad     = 0;
  logic [7:0] mem [0:(1<<ADDR_W)-1];

  vram_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  vram_arbiter #(.ADDR_W(ADDR_W), .MAX_STREAK(4)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  // RAM: output register holds the word at the address present at the edge
  always @(posedge clk_sys) begin
    bus.ram_dout <= mem[bus.ram_addr];
    if (bus.ram_we) mem[bus.ram_addr] = bus.ram_din;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk_sys);
  endtask

  task automatic test_reset();
    tick();
    total++;
    if (bus.ram_we !== 1'b0 || bus.vid_ack !== 1'b0 || bus.cpu_ack !== 1'b0) begin
      bad++;
      $display("FAIL reset_strobes: we=%b vack=%b cack=%b, want 0 0 0", bus.ram_we, bus.vid_ack, bus.cpu_ack);
    end
    total++;
    if (bus.ram_addr !== 16'h0000 || bus.ram_din !== 8'h00) begin
      bad++;
      $display("FAIL reset_ram_bus: addr=%h din=%h, want 0000 00", bus.ram_addr, bus.ram_din);
    end
    total++;
    if (bus.vid_data !== 8'h00 || bus.cpu_dout !== 8'h00) begin
      bad++;
      $display("FAIL reset_data: vid_data=%h cpu_dout=%h, want 00 00", bus.vid_data, bus.cpu_dout);
    end
    reset = 1'b0;
    tick();
    total++;
    if (bus.ram_we !== 1'b0 || bus.vid_ack !== 1'b0 || bus.cpu_ack !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_idle: we=%b vack=%b cack=%b, want 0 0 0", bus.ram_we, bus.vid_ack, bus.cpu_ack);
    end
  endtask

  task automatic test_video_read();
    logic exp_ack;
    mem[16'h0400] = 8'h5A;
    bus.vid_addr = 16'h0400;
    bus.vid_req  = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      exp_ack = (c == 3);
      if (c == 1) begin
        total++;
        if (bus.ram_addr !== 16'h0400 || bus.ram_we !== 1'b0) begin
          bad++;
          $display("FAIL vid_issue: addr=%h we=%b, want 0400 0", bus.ram_addr, bus.ram_we);
        end
        bus.vid_addr = 16'hBEEF;
      end
      total++;
      if (bus.vid_ack !== exp_ack || bus.cpu_ack !== 1'b0) begin
        bad++;
        $display("FAIL vid_ack_timing c=%0d: vack=%b cack=%b, want %b 0", c, bus.vid_ack, bus.cpu_ack, exp_ack);
      end
      if (c == 3) begin
        total++;
        if (bus.vid_data !== 8'h5A) begin
          bad++;
          $display("FAIL vid_data: got %h, want 5a", bus.vid_data);
        end
        bus.vid_req = 1'b0;
      end
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      total++;
      if (bus.vid_ack !== 1'b0 || bus.ram_we !== 1'b0 || bus.ram_addr !== 16'h0400) begin
        bad++;
        $display("FAIL idle_hold c=%0d: vack=%b we=%b addr=%h, want 0 0 0400", c, bus.vid_ack, bus.ram_we, bus.ram_addr);
      end
    end
  endtask

  task automatic test_cpu_write_read();
    int   we_cnt = 0;
    logic exp_ack;
    bus.cpu_addr = 16'h1234;
    bus.cpu_din  = 8'hC3;
    bus.cpu_we   = 1'b1;
    bus.cpu_req  = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (bus.ram_we) we_cnt++;
      exp_ack = (c == 3);
      if (c == 1) begin
        total++;
        if (bus.ram_addr !== 16'h1234 || bus.ram_din !== 8'hC3 || bus.ram_we !== 1'b1) begin
          bad++;
          $display("FAIL cpu_wr_issue: addr=%h din=%h we=%b, want 1234 c3 1", bus.ram_addr, bus.ram_din, bus.ram_we);
        end
        bus.cpu_din = 8'h00;
        bus.cpu_we  = 1'b0;
      end
      total++;
      if (bus.cpu_ack !== exp_ack || bus.vid_ack !== 1'b0) begin
        bad++;
        $display("FAIL cpu_wr_ack c=%0d: cack=%b vack=%b, want %b 0", c, bus.cpu_ack, bus.vid_ack, exp_ack);
      end
      if (c == 3) begin
        total++;
        if (bus.cpu_dout !== 8'h00) begin
          bad++;
          $display("FAIL cpu_dout_on_write: got %h, want 00", bus.cpu_dout);
        end
        bus.cpu_req = 1'b0;
      end
    end
    total++;
    if (we_cnt !== 1) begin
      bad++;
      $display("FAIL we_pulse_count: got %0d, want 1", we_cnt);
    end
    total++;
    if (mem[16'h1234] !== 8'hC3) begin
      bad++;
      $display("FAIL ram_written: got %h, want c3", mem[16'h1234]);
    end
    bus.cpu_we  = 1'b0;
    bus.cpu_req = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      exp_ack = (c == 3);
      total++;
      if (bus.cpu_ack !== exp_ack || bus.ram_we !== 1'b0) begin
        bad++;
        $display("FAIL cpu_rd_ack c=%0d: cack=%b we=%b, want %b 0", c, bus.cpu_ack, bus.ram_we, exp_ack);
      end
      if (c == 3) begin
        total++;
        if (bus.cpu_dout !== 8'hC3) begin
          bad++;
          $display("FAIL cpu_rd_data: got %h, want c3", bus.cpu_dout);
        end
        bus.cpu_req = 1'b0;
      end
    end
    tick();
  endtask

  task automatic test_streak();
    int   n = 0;
    logic exp_cpu;
    mem[16'h0010] = 8'h11;
    mem[16'h0020] = 8'h22;
    bus.vid_addr = 16'h0010;
    bus.cpu_addr = 16'h0020;
    bus.cpu_we   = 1'b0;
    bus.vid_req  = 1'b1;
    bus.cpu_req  = 1'b1;
    for (int c = 0; c < 60 && n < 10; c++) begin
      tick();
      if (bus.vid_ack || bus.cpu_ack) begin
        exp_cpu = (n % 5 == 4);
        total++;
        if (bus.cpu_ack !== exp_cpu || bus.vid_ack !== !exp_cpu ||
            (exp_cpu && bus.cpu_dout !== 8'h22) || (!exp_cpu && bus.vid_data !== 8'h11)) begin
          bad++;
          $display("FAIL streak_order n=%0d: cack=%b vack=%b vdata=%h cdout=%h, want cack=%b vack=%b",
                   n, bus.cpu_ack, bus.vid_ack, bus.vid_data, bus.cpu_dout, exp_cpu, !exp_cpu);
        end
        n++;
        if (n == 10) begin
          bus.vid_req = 1'b0;
          bus.cpu_req = 1'b0;
        end
      end
    end
    total++;
    if (n != 10) begin
      bad++;
      $display("FAIL streak_count: got %0d acks, want 10", n);
    end
    bus.vid_req = 1'b0;
    bus.cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_req_drop();
    logic exp_ack;
    mem[16'h0030] = 8'h7E;
    bus.cpu_addr = 16'h0030;
    bus.cpu_we   = 1'b0;
    bus.cpu_req  = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 2) bus.cpu_req = 1'b0;
      exp_ack = (c == 3);
      total++;
      if (bus.cpu_ack !== exp_ack) begin
        bad++;
        $display("FAIL drop_ack c=%0d: cack=%b, want %b", c, bus.cpu_ack, exp_ack);
      end
    end
    total++;
    if (bus.cpu_dout !== 8'h7E) begin
      bad++;
      $display("FAIL drop_data: got %h, want 7e", bus.cpu_dout);
    end
  endtask

  task automatic test_reset_mid_write();
    bus.cpu_addr = 16'h3000;
    bus.cpu_din  = 8'h55;
    bus.cpu_we   = 1'b1;
    bus.cpu_req  = 1'b1;
    tick();
    total++;
    if (bus.ram_we !== 1'b1) begin
      bad++;
      $display("FAIL midrst_issue: we=%b, want 1", bus.ram_we);
    end
    #1 reset = 1'b1;
    #1;
    total++;
    if (bus.ram_we !== 1'b0) begin
      bad++;
      $display("FAIL midrst_we: got %b, want 0", bus.ram_we);
    end
    total++;
    if (bus.ram_addr !== 16'h0000 || bus.ram_din !== 8'h00 || bus.vid_data !== 8'h00 ||
        bus.cpu_dout !== 8'h00 || bus.vid_ack !== 1'b0 || bus.cpu_ack !== 1'b0) begin
      bad++;
      $display("FAIL midrst_outputs: addr=%h din=%h vd=%h cd=%h vack=%b cack=%b, want all 0",
               bus.ram_addr, bus.ram_din, bus.vid_data, bus.cpu_dout, bus.vid_ack, bus.cpu_ack);
    end
    bus.cpu_req = 1'b0;
    bus.cpu_we  = 1'b0;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      total++;
      if (bus.cpu_ack !== 1'b0) begin
        bad++;
        $display("FAIL midrst_no_ack c=%0d: cack=%b, want 0", c, bus.cpu_ack);
      end
    end
    total++;
    if (mem[16'h3000] !== 8'h00) begin
      bad++;
      $display("FAIL midrst_ram: got %h, want 00", mem[16'h3000]);
    end
  endtask

`ifdef VRAM_ARB_DMA_EN
  task automatic test_dma();
    logic exp_ack;
    bus.dma_addr = 16'h4000;
    bus.dma_din  = 8'hA7;
    bus.dma_req  = 1'b1;
    bus.vid_addr = 16'h0010;
    bus.vid_req  = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      exp_ack = (c == 3);
      if (c == 1) begin
        total++;
        if (bus.ram_we !== 1'b1 || bus.ram_addr !== 16'h4000) begin
          bad++;
          $display("FAIL dma_issue: we=%b addr=%h, want 1 4000", bus.ram_we, bus.ram_addr);
        end
      end
      total++;
      if (bus.dma_ack !== exp_ack || bus.vid_ack !== 1'b0) begin
        bad++;
        $display("FAIL dma_first c=%0d: dack=%b vack=%b, want %b 0", c, bus.dma_ack, bus.vid_ack, exp_ack);
      end
      if (c == 3) bus.dma_req = 1'b0;
    end
    for (int c = 1; c <= 4; c++) begin
      tick();
      exp_ack = (c == 4);
      total++;
      if (bus.vid_ack !== exp_ack) begin
        bad++;
        $display("FAIL dma_then_vid c=%0d: vack=%b, want %b", c, bus.vid_ack, exp_ack);
      end
      if (c == 4) bus.vid_req = 1'b0;
    end
    total++;
    if (mem[16'h4000] !== 8'hA7) begin
      bad++;
      $display("FAIL dma_ram: got %h, want a7", mem[16'h4000]);
    end
    tick();
  endtask
`endif

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'h00;
    bus.vid_req  = 1'b0;
    bus.vid_addr = '0;
    bus.cpu_req  = 1'b0;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_din  = '0;
`ifdef VRAM_ARB_DMA_EN
    bus.dma_req  = 1'b0;
    bus.dma_addr = '0;
    bus.dma_din  = '0;
`endif
    test_reset();
    test_video_read();
    test_cpu_write_read();
    test_streak();
    test_req_drop();
    test_reset_mid_write();
`ifdef VRAM_ARB_DMA_EN
    test_dma();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16: address width of all address ports.
REQ-002 Parameter MAX_STREAK, default 4: consecutive video grants allowed while the CPU waits.
REQ-003 clk_sys  in  1  system clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 vid_req  in  1  video fetch request; level, held until vid_ack.
REQ-006 vid_addr  in  ADDR_W  video fetch address.
REQ-007 vid_ack  out  1  one-cycle pulse; vid_data valid in the same cycle.
REQ-008 vid_data  out  8  read data for video; held until the next video access completes.
REQ-009 cpu_req  in  1  CPU request; level, held until cpu_ack.
REQ-010 cpu_we  in  1  1 = write, 0 = read; sampled at grant.
REQ-011 cpu_addr  in  ADDR_W  CPU address.
REQ-012 cpu_din  in  8  CPU write data.
REQ-013 cpu_ack  out  1  one-cycle completion pulse for read or write.
REQ-014 cpu_dout  out  8  CPU read data; held until the next CPU read completes.
REQ-015 ram_addr  out  ADDR_W  registered address to the synchronous single-port RAM.
REQ-016 ram_we  out  1  registered RAM write strobe.
REQ-017 ram_din  out  8  registered write data to the RAM.
REQ-018 ram_dout  in  8  RAM read data; valid the cycle after the RAM samples its address.

Function
REQ-019 The FSM SHALL have states IDLE, ISSUE, CAPTURE and ACK; each access takes exactly ISSUE, CAPTURE, ACK, then returns to IDLE.
REQ-020 Arbitration SHALL occur only in IDLE: requests sampled in cycle N give ISSUE in N+1, CAPTURE in N+2, and ack in N+3.
REQ-021 In ISSUE, ram_addr and ram_din SHALL hold the granted requester's address and data; ram_we = 1 only for a CPU write.
REQ-022 ram_we SHALL be 1 for exactly one cycle per write and 0 in every other state.
REQ-023 At the edge ending CAPTURE, ram_dout SHALL be registered into vid_data (video grant) or cpu_dout (CPU read); cpu_dout is unchanged on writes.
REQ-024 Priority SHALL be video over CPU unless the streak limit is reached.
REQ-025 Streak limit: when streak == MAX_STREAK and both requests are pending, the CPU SHALL win.
REQ-026 streak SHALL increment on each video grant made while cpu_req = 1, saturating at MAX_STREAK.
REQ-027 streak SHALL clear on any CPU grant and in any IDLE cycle with cpu_req = 0.
REQ-028 Once granted, an access SHALL complete and pulse its ack even if the request drops mid-access.
REQ-029 A requester SHALL deassert req in the cycle after its ack, or keep it high to request a new access; IDLE treats a held req as a new request.
REQ-030 Address and data inputs SHALL be latched at grant; later changes SHALL NOT affect the access in flight.
REQ-031 IDLE with no request SHALL keep ram_we = 0 and ram_addr unchanged.

Reset
REQ-032 While reset = 1, state SHALL be IDLE and ram_we, vid_ack, cpu_ack and streak SHALL be 0.
REQ-033 While reset = 1, ram_addr, ram_din, vid_data and cpu_dout SHALL be 0.
REQ-034 Reset mid-access SHALL abandon the access with no ack; a write in ISSUE SHALL have ram_we cleared asynchronously.

Configuration
REQ-035 With VRAM_ARB_DMA_EN defined, ports dma_req (in 1), dma_addr (in ADDR_W), dma_din (in 8) and dma_ack (out 1) SHALL exist.
REQ-036 With VRAM_ARB_DMA_EN defined, DMA is write-only, has priority above video and CPU, uses the same ISSUE/CAPTURE/ACK timing, and does not alter streak.
REQ-037 Without VRAM_ARB_DMA_EN, the DMA ports and all DMA logic SHALL be absent and behaviour SHALL be as REQ-019..031.

Verification
REQ-038 Video read: RAM[0x0400] = 0x5A, vid_req with vid_addr = 0x0400 in cycle 0 -> vid_ack = 1 and vid_data = 0x5A in cycle 3, with no other ack.
REQ-039 CPU write then read: write 0xC3 to 0x1234, then read 0x1234 -> ram_we high for exactly one cycle, and cpu_dout = 0xC3 at the second cpu_ack.
REQ-040 Simultaneous requests: vid_req and cpu_req both held continuously -> 4 vid_acks, then 1 cpu_ack, repeating; CPU wait never exceeds 4 accesses.
REQ-041 Reset mid-write: reset asserted during ISSUE of a CPU write -> ram_we falls immediately, no cpu_ack, and all outputs are 0.
REQ-042 Request drop: cpu_req dropped in CAPTURE -> cpu_ack still pulses once; with VRAM_ARB_DMA_EN, dma_req plus vid_req together -> dma_ack first.
